// File: rtl/spi_minion_pkg.sv
// Shared types for the SPI minion endpoint.
package spi_minion_pkg;

  // Frame-level FSM: waiting for chip select, shifting bits, or holding after a full word
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_HOLD  = 2'd2
  } state_e;

endpackage

// File: rtl/spi_sync.sv
// Two-flop synchronizer for an asynchronous pin plus a third flop for edge detection.
module spi_sync (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic sync,
  output logic pos,
  output logic neg
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  // Synchronizer chain and previous-value flop, all cleared by reset
  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= din;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign sync = sync_q;
  assign pos  = sync_q & ~prev_q;
  assign neg  = ~sync_q & prev_q;

endmodule

// File: rtl/spi_minion.sv
// SPI mode-0 minion: oversampled pins, one word per chip-select frame, val/rdy on both sides.
module spi_minion
  import spi_minion_pkg::*;
#(
  parameter int unsigned nbits = 34
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cs,
  input  logic             sclk,
  input  logic             mosi,
  output logic             miso,
  input  logic             recv_val,
  output logic             recv_rdy,
  input  logic [nbits-1:0] recv_msg,
  output logic             send_val,
  input  logic             send_rdy,
  output logic [nbits-1:0] send_msg
);

  localparam int unsigned CW = $clog2(nbits + 1);

  logic cs_sync, cs_fall, cs_rise;
  logic sclk_sync, sclk_pos, sclk_neg;
  logic mosi_sync, mosi_pos, mosi_neg;
  logic unused_sync;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [nbits-1:0] rx_q, rx_d;
  logic [nbits-1:0] tx_q, tx_d;
  logic [nbits-1:0] buf_q, buf_d;
  logic             empty_q, empty_d;
  logic [nbits-1:0] send_msg_q, send_msg_d;
  logic             send_val_q, send_val_d;
  logic             miso_q, miso_d;

  spi_sync u_sync_cs (
    .clk   (clk),
    .reset (reset),
    .din   (cs),
    .sync  (cs_sync),
    .pos   (cs_rise),
    .neg   (cs_fall)
  );

  spi_sync u_sync_sclk (
    .clk   (clk),
    .reset (reset),
    .din   (sclk),
    .sync  (sclk_sync),
    .pos   (sclk_pos),
    .neg   (sclk_neg)
  );

  spi_sync u_sync_mosi (
    .clk   (clk),
    .reset (reset),
    .din   (mosi),
    .sync  (mosi_sync),
    .pos   (mosi_pos),
    .neg   (mosi_neg)
  );

  // Levels/edges not needed by the frame logic
  assign unused_sync = ^{cs_sync, sclk_sync, mosi_pos, mosi_neg};

  // Next-state logic: tx buffer, frame FSM, shift registers and receive handshake
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rx_d       = rx_q;
    tx_d       = tx_q;
    buf_d      = buf_q;
    empty_d    = empty_q;
    send_msg_d = send_msg_q;
    send_val_d = send_val_q;
    miso_d     = 1'b0;

    // Buffer accepts a tx word only while empty; never coincides with a buffer unload
    if (recv_val && empty_q) begin
      buf_d   = recv_msg;
      empty_d = 1'b0;
    end

    if (send_val_q && send_rdy) begin
      send_val_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (cs_fall) begin
          state_d = ST_SHIFT;
          cnt_d   = '0;
          if (!empty_q) begin
            tx_d    = buf_q;
            empty_d = 1'b1;
          end else begin
            tx_d = '0;
          end
        end
      end
      ST_SHIFT: begin
        if (cs_rise) begin
          state_d = ST_IDLE;
        end else if (sclk_pos) begin
          rx_d  = {rx_q[nbits-2:0], mosi_sync};
          cnt_d = cnt_q + CW'(1);
          if (cnt_d == CW'(nbits)) begin
            state_d = ST_HOLD;
            // A word still waiting for the consumer wins over the new one
            if (!send_val_q || send_rdy) begin
              send_msg_d = rx_d;
              send_val_d = 1'b1;
            end
          end
        end else if (sclk_neg) begin
          tx_d = {tx_q[nbits-2:0], 1'b0};
        end
      end
      ST_HOLD: begin
        if (cs_rise) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // miso is driven only while shifting, from the next output-register MSB
    miso_d = (state_d == ST_SHIFT) && tx_d[nbits-1];
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      rx_q       <= '0;
      tx_q       <= '0;
      buf_q      <= '0;
      empty_q    <= 1'b1;
      send_msg_q <= '0;
      send_val_q <= 1'b0;
      miso_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rx_q       <= rx_d;
      tx_q       <= tx_d;
      buf_q      <= buf_d;
      empty_q    <= empty_d;
      send_msg_q <= send_msg_d;
      send_val_q <= send_val_d;
      miso_q     <= miso_d;
    end
  end

  assign miso     = miso_q;
  assign recv_rdy = empty_q;
  assign send_val = send_val_q;
  assign send_msg = send_msg_q;

endmodule

// File: doc/spi_minion.md
# spi_minion

SPI minion (responder) endpoint: the far end of the team's SPI master, for use in peripherals and loopback test harnesses. It oversamples the `cs`/`sclk`/`mosi` pins on the system clock, shifts in one `nbits` word per chip-select frame, and delivers it on a val/rdy output interface. It simultaneously shifts out a word previously accepted on a val/rdy input interface on `miso`. The protocol is SPI mode 0 (CPOL=0, CPHA=0), MSB first.

## Interface
- `nbits`, 34, word length in bits per frame (≥2)
- `clk`  input  1  system clock; all logic on posedge
- `reset`  input  1  synchronous, active-high reset
- `cs`  input  1  chip select from master, active low, asynchronous to `clk`
- `sclk`  input  1  SPI clock from master, asynchronous to `clk`
- `mosi`  input  1  serial data from master
- `miso`  output  1  serial data to master, always driven (no tristate); 0 when idle
- `recv_val`  input  1  word to transmit is valid
- `recv_rdy`  output  1  transmit buffer empty
- `recv_msg`  input  nbits  word to transmit on `miso` in the next frame
- `send_val`  output  1  received word valid
- `send_rdy`  input  1  consumer accepts received word
- `send_msg`  output  nbits  word received from `mosi`

## Operation
- Input conditioning:
  - Each of `cs`, `sclk`, `mosi` passes through a 2-flop synchronizer, then a third flop for edge detection.
  - `sclk_pos` = sync & ~prev; `sclk_neg` = ~sync & prev.
  - `cs_fall` and `cs_rise` are derived from the synced `cs` in the same way.
- Transmit buffer: one `nbits` register plus a full flag.
  - `recv_rdy` = ~full.
  - A transfer occurs when `recv_val & recv_rdy` and sets full.
- FSM states: IDLE, SHIFT, HOLD.
  - IDLE → SHIFT on `cs_fall`.
    - Output shift register loads the tx buffer if full (clears full); otherwise it loads all zeros.
    - Bit counter clears to 0.
  - SHIFT:
    - On `sclk_pos`: shift the synced `mosi` into the input shift register LSB and increment the counter.
    - On `sclk_neg`: shift the output register left, filling with 0.
    - `miso` = output register MSB, so bit nbits-1 is on `miso` before the first `sclk` rise.
    - When the counter reaches `nbits` on an `sclk_pos`, the complete word (including that final bit) is captured into `send_msg`, then → HOLD.
  - HOLD: further `sclk` edges are ignored and `miso` = 0.
  - SHIFT or HOLD → IDLE on `cs_rise`. A partial word (fewer than `nbits` bits) is discarded silently: `send_val` is unaffected.
- Receive output:
  - `send_val` is set at word capture and cleared on `send_rdy & send_val`.
  - Overrun: if `send_val` is still high when a new word completes, the new word is dropped and the held word is unchanged.
- Simultaneous events: capture and `send_rdy` acceptance in the same cycle → the new word is loaded and `send_val` stays 1. A `recv` transfer in the same cycle as `cs_fall` (buffer was empty) → frame sends zeros and the new word stays buffered.
- Reset:
  - IDLE; counter 0; both shift registers 0; tx buffer empty; synchronizer flops 0; `send_msg` 0.
  - If `cs` is low when reset releases, the block waits for a `cs` rise then fall; no mid-frame join.

## Timing
- Reset values: `miso`=0, `recv_rdy`=1, `send_val`=0, `send_msg`=0.
- Pin-to-action latency: a pin edge is acted on at the 3rd `clk` posedge after it.
  - `send_val` rises 3 `clk` edges after the `nbits`-th `sclk` rise at the pin.
  - `miso` changes 3 `clk` edges after the `sclk` fall.
- Requirements on the master:
  - `sclk` high and low phases ≥ 4 `clk` periods.
  - `cs` fall to first `sclk` rise ≥ 4 `clk` periods.
  - `mosi` stable across each synchronized `sclk` rise.
- `recv_rdy` rises the cycle after the buffer is emptied by `cs_fall`. It is not combinationally dependent on `recv_val`.

## Structure
- Package `spi_minion_pkg`: FSM state enum (IDLE, SHIFT, HOLD).
- Sub-module `spi_sync`: 2-flop synchronizer plus edge detector with outputs `sync`, `pos`, `neg`; instantiated three times.
- Counter width: $clog2(nbits+1).

## Test plan
- Buffer tx word 0x2_AAAA_5555, then a 34-bit frame with `mosi` = 0x1_2345_6789 → `miso` bits equal 0x2AAAA5555 MSB first; `send_val`=1, `send_msg`=0x123456789; `recv_rdy` back to 1.
- Frame with no buffered tx word → `miso` stays 0 for all 34 bits; rx word delivered normally.
- `cs` rises after 10 bits → `send_val` stays 0; next full frame of 0x3_FFFF_FFFF is received correctly.
- Hold `send_rdy`=0 across two frames (0x1, then 0x2) → `send_msg` stays 0x1; after handshake `send_val`=0.
- 40 `sclk` pulses in one frame → word captured after bit 34; extra pulses ignored and `miso`=0 in HOLD.
- Assert `reset` at bit 17 with `cs` still low → outputs go to reset values; block ignores rest of frame and the next full frame works.
